window_fetch7: RTL and testbench

- Upstream neighbour of the 7x7 Gaussian stage: accepts one event address and reads the 49-pixel neighbourhood from a synchronous pixel memory, one word per cycle.
- Assembles the neighbourhood into a packed 7x7 window and hands it downstream under the downstream window_req handshake.
- Pixels outside the image are zero-filled. Addresses outside the image are dropped and counted.

---
 rtl/window_fetch7.sv | 91 +++++++++
 tb/tb_window_fetch7.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/window_fetch7.sv
// window_fetch7: fetches a zero-padded 7x7 neighbourhood around an event address and hands it downstream
// ports: in_event_addr/valid/ready accept {y,x}; mem_rd_en/addr/data drive a 1-cycle-latency pixel memory;
//        window_req + out_window_value/valid/addr deliver the packed window; drop_cnt counts out-of-image events
module window_fetch7 #(
  parameter int DATA_WIDTH = 14,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                in_event_addr,
  input  logic                       in_event_valid,
  output logic                       in_event_ready,
  output logic                       mem_rd_en,
  output logic [15:0]                mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  input  logic                       window_req,
  output logic [DATA_WIDTH*49-1:0]   out_window_value,
  output logic                       out_window_valid,
  output logic [15:0]                out_window_addr,
  output logic [15:0]                drop_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
  localparam logic signed [9:0] W = 10'(IMG_W);
  localparam logic signed [9:0] H = 10'(IMG_H);
  localparam logic [8:0] W9 = 9'(IMG_W);
  localparam logic [8:0] H9 = 9'(IMG_H);
  state_t state;
  logic [7:0] ax, ay;
  logic [5:0] k, cap_k;
  logic [2:0] r, c;
  logic cap_en, cap_in, slot_in, ev_in;
  logic signed [9:0] sx, sy;
  logic [DATA_WIDTH-1:0] win [49];
  assign sx = $signed({2'b00, ax}) + $signed({7'b0, c}) - 10'sd3;
  assign sy = $signed({2'b00, ay}) + $signed({7'b0, r}) - 10'sd3;
  assign slot_in = sx >= 10'sd0 && sx < W && sy >= 10'sd0 && sy < H;
  assign ev_in = {1'b0, in_event_addr[7:0]} < W9 && {1'b0, in_event_addr[15:8]} < H9;
  assign in_event_ready = state == IDLE;
  assign mem_rd_en = state == FETCH && slot_in;
  assign mem_rd_addr = mem_rd_en ? {sy[7:0], sx[7:0]} : 16'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ax <= '0;
      ay <= '0;
      k <= '0;
      r <= '0;
      c <= '0;
      cap_en <= 1'b0;
      cap_in <= 1'b0;
      cap_k <= '0;
      for (int i = 0; i < 49; i++) win[i] <= '0;
      out_window_value <= '0;
      out_window_valid <= 1'b0;
      out_window_addr <= '0;
      drop_cnt <= '0;
    end else begin
      out_window_valid <= 1'b0;
      cap_en <= state == FETCH;
      cap_k <= k;
      cap_in <= slot_in;
      if (cap_en) win[cap_k] <= cap_in ? mem_rd_data : '0;
      case (state)
        IDLE: if (in_event_valid) begin
          if (ev_in) begin
            ax <= in_event_addr[7:0];
            ay <= in_event_addr[15:8];
            k <= '0;
            r <= '0;
            c <= '0;
            state <= FETCH;
          end else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        FETCH: begin
          k <= k + 6'd1;
          c <= c == 3'd6 ? 3'd0 : c + 3'd1;
          r <= c == 3'd6 ? r + 3'd1 : r;
          if (k == 6'd48) state <= DRAIN;
        end
        DRAIN: state <= HOLD;
        default: if (window_req) begin
          for (int i = 0; i < 49; i++) out_window_value[DATA_WIDTH*i +: DATA_WIDTH] <= win[i];
          out_window_valid <= 1'b1;
          out_window_addr <= {ay, ax};
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_window_fetch7.sv
// tb_window_fetch7: scoreboard bench for window_fetch7
module tb_window_fetch7;
  localparam int DW = 14;
  localparam int IW = 128;
  localparam int IH = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] in_event_addr;
  logic in_event_valid, in_event_ready, mem_rd_en, window_req, out_window_valid;
  logic [15:0] mem_rd_addr, out_window_addr, drop_cnt;
  logic [DW-1:0] mem_rd_data;
  logic [DW*49-1:0] out_window_value;
  always #5 clk = ~clk;
  window_fetch7 #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .in_event_addr(in_event_addr), .in_event_valid(in_event_valid),
    .in_event_ready(in_event_ready), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .window_req(window_req), .out_window_value(out_window_value),
    .out_window_valid(out_window_valid), .out_window_addr(out_window_addr), .drop_cnt(drop_cnt)
  );
  typedef struct {
    logic [DW*49-1:0] w;
    logic [15:0] a;
    int acc;
    bit lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, strb_cnt = 0, rd_cnt = 0, neg_rd = 0, stab_bad = 0;
  int last_strb = 0, acc = 0;
  logic [DW*49-1:0] last_val = '0;
  logic [15:0] last_addr = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [DW*49-1:0] exp_win(input int x, input int y);
    logic [DW*49-1:0] w;
    int sx, sy;
    w = '0;
    for (int k = 0; k < 49; k++) begin
      sx = x - 3 + k % 7;
      sy = y - 3 + k / 7;
      if (sx >= 0 && sx < IW && sy >= 0 && sy < IH) w[DW*k +: DW] = 14'((sy * 256 + sx) & 16383);
    end
    return w;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? mem_rd_addr[13:0] : 14'($urandom);
  end
  always @(negedge clk) begin
    if (rst) begin
      last_val = '0;
      last_addr = '0;
    end else if (out_window_valid) begin
      strb_cnt++;
      last_strb = cyc;
      if (q.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("win_addr", 32'(out_window_addr), 32'(e.a));
        for (int k = 0; k < 49; k++) chk("slot", 32'(out_window_value[DW*k +: DW]), 32'(e.w[DW*k +: DW]));
        if (e.lat) chk("latency", cyc - e.acc + 1, 52);
      end
      last_val = out_window_value;
      last_addr = out_window_addr;
    end else if (out_window_value !== last_val || out_window_addr !== last_addr) stab_bad++;
    if (mem_rd_en) begin
      rd_cnt++;
      if (mem_rd_addr[7:0] >= IW || mem_rd_addr[15:8] >= IH) neg_rd++;
    end
  end
  task automatic send(input int x, input int y, input bit lat, input bit pre, input bit keep);
    int n = 0;
    exp_t s;
    if (pre) @(negedge clk);
    in_event_addr = {8'(y), 8'(x)};
    in_event_valid = 1'b1;
    while (!in_event_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_event_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) in_event_valid = 1'b0;
    if (x < IW && y < IH) begin
      s.w = exp_win(x, y);
      s.a = {8'(y), 8'(x)};
      s.acc = acc;
      s.lat = lat;
      q.push_back(s);
    end
  endtask
  task automatic wait_strobe(input int n0);
    int n = 0;
    while (strb_cnt == n0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("strobe_seen", 32'(strb_cnt != n0), 32'd1);
  endtask
  initial begin
    int r0, n0, a1, s1;
    in_event_valid = 1'b0;
    in_event_addr = '0;
    window_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(in_event_ready), 32'd1);
    chk("rst_valid", 32'(out_window_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_addr", 32'(out_window_addr), 32'd0);
    chk("rst_value", 32'(|out_window_value), 32'd0);
    r0 = rd_cnt; n0 = strb_cnt;
    send(20, 10, 1, 1, 0);
    wait_strobe(n0);
    chk("rd_cnt_20_10", rd_cnt - r0, 49);
    chk("slot0", 32'(out_window_value[13:0]), 1809);
    chk("slot24", 32'(out_window_value[DW*24 +: DW]), 2580);
    chk("slot48", 32'(out_window_value[DW*48 +: DW]), 3351);
    chk("addr_0a14", 32'(out_window_addr), 32'h0A14);
    r0 = rd_cnt; n0 = strb_cnt;
    send(0, 0, 1, 1, 0);
    wait_strobe(n0);
    chk("rd_cnt_0_0", rd_cnt - r0, 16);
    chk("slot48_0_0", 32'(out_window_value[DW*48 +: DW]), 771);
    chk("neg_reads", neg_rd, 0);
    window_req = 1'b0;
    n0 = strb_cnt;
    send(20, 10, 0, 1, 0);
    in_event_addr = {8'd30, 8'd30};
    in_event_valid = 1'b1;
    repeat (150) begin
      @(negedge clk);
      #1;
      chk("stall_strobe", strb_cnt, n0);
      chk("stall_ready", 32'(in_event_ready), 32'd0);
    end
    in_event_valid = 1'b0;
    window_req = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_release", 32'(out_window_valid), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("stall_single", strb_cnt, n0 + 1);
    r0 = rd_cnt; n0 = strb_cnt;
    send(200, 10, 1, 1, 0);
    repeat (60) begin
      @(negedge clk);
      #1;
      chk("drop_ready", 32'(in_event_ready), 32'd1);
    end
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_rd", rd_cnt - r0, 0);
    chk("drop_strobe", strb_cnt, n0);
    n0 = strb_cnt;
    send(20, 10, 1, 1, 1);
    a1 = acc;
    send(21, 10, 1, 0, 0);
    s1 = last_strb;
    chk("b2b_first", strb_cnt, n0 + 1);
    chk("b2b_accept", acc - 1, s1);
    chk("b2b_first_lat", s1 - a1 + 1, 52);
    wait_strobe(n0 + 1);
    chk("b2b_gap", last_strb - s1, 52);
    send(20, 10, 1, 1, 0);
    repeat (21) @(negedge clk);
    #1;
    chk("k20_rd_en", 32'(mem_rd_en), 32'd1);
    chk("k20_rd_addr", 32'(mem_rd_addr), 32'h0917);
    rst = 1'b1;
    #1;
    chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
    chk("abort_valid", 32'(out_window_valid), 32'd0);
    chk("abort_addr", 32'(out_window_addr), 32'd0);
    chk("abort_value", 32'(|out_window_value), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'd0);
    chk("abort_ready", 32'(in_event_ready), 32'd1);
    q.delete();
    n0 = strb_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("abort_no_strobe", strb_cnt, n0);
    send(5, 5, 1, 1, 0);
    wait_strobe(n0);
    chk("addr_0505", 32'(out_window_addr), 32'h0505);
    repeat (3) @(negedge clk);
    chk("addr_stable", stab_bad, 0);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
